result_streamer: RTL and testbench
==================================

Name: result_streamer

Overview:
- Output-side counterpart of the serial input loader. The loader consumes input bytes on DI; this block drives result bytes out.
- When the control unit signals completion, the block captures the NO_NOL quantized output-layer activations (PQ values from the MAC) and computes the argmax sequentially.
- It then transmits a byte stream off-chip over a valid/ready handshake: the class index first, then all scores.
- Sits beside ctrl_unit and mac in the top level.

Parameters:
- NO_NOL, 10, number of output-layer neurons captured and streamed.
- DW, 8, width of each quantized activation (signed two's complement).
- IDX_W, 4, width of the class index; must satisfy 2^IDX_W >= NO_NOL.

Ports:
- clk, input, 1, single system clock; all logic rising-edge.
- rst, input, 1, asynchronous active-low reset.
- done, input, 1, single-cycle completion pulse from ctrl_unit.
- pq_in, input, NO_NOL*DW, packed quantized outputs; neuron i occupies bits [i*DW +: DW].
- dout, output, DW, stream data byte.
- dout_valid, output, 1, dout holds a valid byte.
- dout_ready, input, 1, downstream accepts the byte.
- dout_last, output, 1, marks the final byte of a frame.
- class_idx, output, IDX_W, argmax result register.
- class_valid, output, 1, class_idx valid; held until the next capture.
- busy, output, 1, high in any state other than IDLE.
- overrun, output, 1, sticky; set when done arrives while busy.

Behaviour:
- Reset (rst=0, asynchronous) drives:
  - state to IDLE;
  - dout, dout_valid, dout_last, class_idx, class_valid, busy and overrun to 0;
  - the score buffer and counters to 0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is held valid after reset.
- States: IDLE, SCAN, HDR, DATA.
- IDLE:
  - On done=1, latch all NO_NOL pq_in values into the buffer in that same cycle (call it cycle C).
  - Clear class_valid and overrun, then go to SCAN.
- SCAN:
  - One compare per cycle, index k = 0..NO_NOL-1.
  - Running max and index start at buf[0] and 0.
  - Update only when buf[k] > max, using a signed, strict comparison, so ties resolve to the lowest index.
  - After NO_NOL cycles, register class_idx, assert class_valid and go to HDR.
  - class_valid rises at cycle C+1+NO_NOL.
- HDR:
  - dout = class_idx zero-extended to DW; dout_valid=1; dout_last=0.
  - On dout_valid & dout_ready, go to DATA with byte index j=0.
- DATA:
  - dout = buf[j]; dout_valid=1; dout_last=1 only when j = NO_NOL-1.
  - Each handshake increments j.
  - The handshake with j = NO_NOL-1 drops dout_valid and dout_last on the next edge and returns to IDLE.
- Handshake rules:
  - Once dout_valid is high, dout and dout_last are stable and dout_valid stays high until accepted.
  - A transfer occurs only on the cycle where dout_valid & dout_ready.
  - dout_ready may be high before valid; there is no combinational path from dout_ready to dout_valid.
- Throughput: with dout_ready held high, one byte per cycle. A frame is NO_NOL+1 bytes; the first byte is presented at cycle C+1+NO_NOL.
- done while busy is ignored (the buffer is not disturbed) and sets overrun. overrun clears only on reset or on the next accepted capture.
- done in the same cycle that DATA completes its last handshake is treated as busy: it is ignored and sets overrun.
- done held high for several cycles captures once. Later cycles fall in SCAN and set overrun.
- busy = (state != IDLE). It rises the cycle after capture.

Decomposition:
- Shared package nn_pkg holds:
  - NO_NOL, DW and IDX_W defaults;
  - the state encoding constants IDLE/SCAN/HDR/DATA;
  - the frame length constant NO_NOL+1.
- One sub-module, argmax_seq, is natural. It is the sequential signed compare unit, with start, element in, index in, max_idx out and a done flag.
- The FSM, buffer and stream mux stay in result_streamer.

Test Plan:
- Basic argmax and stream: scores {5,-3,20,7,0,1,2,3,4,-128}, done pulse, dout_ready=1.
  - Required: class_idx=2 at C+11.
  - Bytes out: 0x02, 0x05, 0xFD, 0x14, 0x07, 0x00, 0x01, 0x02, 0x03, 0x04, 0x80.
  - dout_last only on 0x80; busy low afterwards.
- Tie and signed compare: scores all -1 except neurons 3 and 6 = 10.
  - Required: class_idx=3.
  - All -128: class_idx=0.
- Backpressure: toggle dout_ready randomly (e.g. 1 of every 3 cycles high).
  - Required: dout and dout_last stable while valid and not ready.
  - Exactly 11 transfers, in order, with no duplicates.
- Overrun: second done pulse during DATA with different pq_in.
  - Required: streamed bytes match the first capture; overrun=1.
  - The next done in IDLE clears overrun.
- Async reset mid-frame: assert rst=0 between edges after 4 bytes are sent.
  - Required: dout_valid, busy and class_valid go to 0 immediately, without a clock edge.
  - After release, a new done produces a complete, correct 11-byte frame.
- Held done: done high for 5 cycles.
  - Required: a single frame is produced and overrun=1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the output-layer result path.
package nn_pkg;

    localparam int NO_NOL_DEF = 10;
    localparam int DW_DEF     = 8;
    localparam int IDX_W_DEF  = 4;

    // One header byte (class index) followed by every score.
    localparam int FRAME_LEN  = NO_NOL_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HDR  = 2'd2,
        DATA = 2'd3
    } state_t;

endpackage

// File: rtl/argmax_seq.sv
// Sequential signed argmax: one element per enabled cycle, strict compare so ties keep the lowest index.
module argmax_seq
    import nn_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             last,
    input  logic [DW-1:0]    elem,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] max_idx,
    output logic             done
);

    logic signed [DW-1:0] max_val;
    logic signed [DW-1:0] cand_val;
    logic [IDX_W-1:0]     best_idx;
    logic [IDX_W-1:0]     cand_idx;

    // max_idx already includes the current element, so the caller can
    // register the final answer on the same edge as the last compare.
    always_comb begin
        cand_val = max_val;
        cand_idx = best_idx;
        if (start) begin
            cand_val = $signed(elem);
            cand_idx = idx;
        end else if ($signed(elem) > max_val) begin
            cand_val = $signed(elem);
            cand_idx = idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the
    // always_comb above uses blocking ones with every output defaulted first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_val  <= '0;
            best_idx <= '0;
        end else if (en) begin
            max_val  <= cand_val;
            best_idx <= cand_idx;
        end
    end

    assign max_idx = cand_idx;
    assign done    = en & last;

endmodule

// File: rtl/result_streamer.sv
// Captures the output-layer activations on done, finds the argmax, then streams
// {class index, score 0 .. score NO_NOL-1} over a valid/ready byte interface.
module result_streamer
    import nn_pkg::*;
#(
    parameter int NO_NOL = NO_NOL_DEF,
    parameter int DW     = DW_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done,
    input  logic [NO_NOL*DW-1:0] pq_in,
    output logic [DW-1:0]        dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic [IDX_W-1:0]     class_idx,
    output logic                 class_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_NOL - 1);

    state_t           state;
    state_t           state_next;
    logic [DW-1:0]    score_buf [NO_NOL];
    logic [IDX_W-1:0] cnt;
    logic             capture;
    logic             xfer;
    logic             cnt_last;
    logic             scan_en;
    logic             scan_start;
    logic             scan_done;
    logic [IDX_W-1:0] scan_idx;
    logic [DW-1:0]    cur_score;

    assign capture    = done && (state == IDLE);
    assign cnt_last   = (cnt == LAST_IDX);
    assign cur_score  = score_buf[cnt];
    assign scan_en    = (state == SCAN);
    assign scan_start = scan_en && (cnt == '0);
    assign xfer       = dout_valid && dout_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: stream outputs decode from registered state only, so dout_ready
    // never reaches dout_valid combinationally and reset clears them at once.
    always_comb begin
        state_next = state;
        dout       = '0;
        dout_valid = 1'b0;
        dout_last  = 1'b0;
        case (state)
            IDLE: if (done) state_next = SCAN;
            SCAN: if (cnt_last) state_next = HDR;
            HDR: begin
                dout       = DW'(class_idx);
                dout_valid = 1'b1;
                if (dout_ready) state_next = DATA;
            end
            DATA: begin
                dout       = cur_score;
                dout_valid = 1'b1;
                dout_last  = cnt_last;
                if (dout_ready && cnt_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the score buffer is reset on purpose so a frame aborted by reset
    // can never leak stale scores into a later frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < NO_NOL; i++) score_buf[i] <= '0;
        end else begin
            if (capture) begin
                for (int i = 0; i < NO_NOL; i++) score_buf[i] <= pq_in[i*DW +: DW];
                cnt         <= '0;
                class_valid <= 1'b0;
                overrun     <= 1'b0;
            end else if (done) begin
                overrun <= 1'b1;
            end

            case (state)
                SCAN: begin
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                    if (scan_done) begin
                        class_idx   <= scan_idx;
                        class_valid <= 1'b1;
                    end
                end
                HDR:  if (xfer) cnt <= '0;
                DATA: if (xfer) cnt <= cnt_last ? '0 : cnt + 1'b1;
                default: ;
            endcase
        end
    end

    argmax_seq #(
        .DW    (DW),
        .IDX_W (IDX_W)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .start   (scan_start),
        .en      (scan_en),
        .last    (cnt_last),
        .elem    (cur_score),
        .idx     (cnt),
        .max_idx (scan_idx),
        .done    (scan_done)
    );

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: table of argmax frames plus backpressure, overrun, reset and held-done sequences.
module tb_result_streamer;
    import nn_pkg::*;

    localparam int NO_NOL = NO_NOL_DEF;
    localparam int DW     = DW_DEF;
    localparam int IDX_W  = IDX_W_DEF;
    localparam int NV     = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 done = 1'b0;
    logic [NO_NOL*DW-1:0] pq_in = '0;
    logic [DW-1:0]        dout;
    logic                 dout_valid;
    logic                 dout_ready = 1'b0;
    logic                 dout_last;
    logic [IDX_W-1:0]     class_idx;
    logic                 class_valid;
    logic                 busy;
    logic                 overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NO_NOL*DW-1:0] pq;
        logic [IDX_W-1:0]     idx;
    } vec_t;

    vec_t vecs [NV];

    result_streamer #(.NO_NOL(NO_NOL), .DW(DW), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .pq_in       (pq_in),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .class_idx   (class_idx),
        .class_valid (class_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NO_NOL*DW-1:0] mk(input int a0, input int a1, input int a2,
                                                input int a3, input int a4, input int a5,
                                                input int a6, input int a7, input int a8,
                                                input int a9);
        return {8'(a9), 8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [DW-1:0] exp_byte(input logic [NO_NOL*DW-1:0] pq,
                                               input logic [IDX_W-1:0] idx, input int i);
        if (i == 0) return DW'(idx);
        return pq[(i-1)*DW +: DW];
    endfunction

    // Leaves the bench at the falling edge right after the capture edge C.
    task automatic start_frame(input logic [NO_NOL*DW-1:0] pq);
        @(negedge clk);
        pq_in = pq;
        done  = 1'b1;
        @(negedge clk);
        done  = 1'b0;
    endtask

    // From just after edge C: class_valid and the header appear after edge C+NO_NOL.
    task automatic scan_timing(input logic [IDX_W-1:0] idx);
        repeat (NO_NOL - 1) @(negedge clk);
        check("class_valid_early", 32'(class_valid), 32'd0);
        check("dout_valid_early", 32'(dout_valid), 32'd0);
        @(negedge clk);
        check("class_valid_rise", 32'(class_valid), 32'd1);
        check("class_idx", 32'(class_idx), 32'(idx));
        check("hdr_valid", 32'(dout_valid), 32'd1);
    endtask

    task automatic collect(input logic [NO_NOL*DW-1:0] pq, input logic [IDX_W-1:0] idx,
                           input bit random_ready, input int nbytes, input int done_at,
                           input logic [NO_NOL*DW-1:0] alt_pq,
                           output int got, output int cycles);
        logic [DW-1:0] prev_dout = '0;
        logic          prev_last = 1'b0;
        bit            held = 1'b0;
        bit            sent = 1'b0;
        bit            rdy;
        got = 0;
        for (cycles = 0; cycles < 400 && got < nbytes; cycles++) begin
            if (held) begin
                check("hold_valid", 32'(dout_valid), 32'd1);
                check("hold_data", 32'(dout), 32'(prev_dout));
                check("hold_last", 32'(dout_last), 32'(prev_last));
            end
            if (done) done = 1'b0;
            else if (!sent && got == done_at) begin
                pq_in = alt_pq;
                done  = 1'b1;
                sent  = 1'b1;
            end
            rdy        = random_ready ? ($urandom_range(0, 2) == 0) : 1'b1;
            dout_ready = rdy;
            held       = 1'b0;
            if (dout_valid) begin
                if (rdy) begin
                    check($sformatf("byte%0d", got), 32'(dout), 32'(exp_byte(pq, idx, got)));
                    check($sformatf("last%0d", got), 32'(dout_last), 32'(got == FRAME_LEN - 1));
                    got++;
                end else begin
                    held      = 1'b1;
                    prev_dout = dout;
                    prev_last = dout_last;
                end
            end
            @(negedge clk);
        end
        done = 1'b0;
    endtask

    initial begin
        int got;
        int cycles;
        int busy_cnt;

        vecs[0] = '{mk(5, -3, 20, 7, 0, 1, 2, 3, 4, -128), 4'd2};
        vecs[1] = '{mk(-1, -1, -1, 10, -1, -1, 10, -1, -1, -1), 4'd3};
        vecs[2] = '{mk(-128, -128, -128, -128, -128, -128, -128, -128, -128, -128), 4'd0};
        vecs[3] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 127), 4'd9};
        vecs[4] = '{mk(-5, -4, -3, -2, -1, -1, -2, -3, -4, -5), 4'd4};

        #12;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_last", 32'(dout_last), 32'd0);
        check("rst_class_idx", 32'(class_idx), 32'd0);
        check("rst_class_valid", 32'(class_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table of full frames with the sink always ready.
        for (int v = 0; v < NV; v++) begin
            start_frame(vecs[v].pq);
            check("busy_after_capture", 32'(busy), 32'd1);
            scan_timing(vecs[v].idx);
            collect(vecs[v].pq, vecs[v].idx, 1'b0, FRAME_LEN, -1, '0, got, cycles);
            check("frame_bytes", 32'(got), 32'(FRAME_LEN));
            check("frame_cycles", 32'(cycles), 32'(FRAME_LEN));
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_valid", 32'(dout_valid), 32'd0);
            check("class_valid_held", 32'(class_valid), 32'd1);
        end

        // Random backpressure.
        start_frame(vecs[0].pq);
        scan_timing(vecs[0].idx);
        collect(vecs[0].pq, vecs[0].idx, 1'b1, FRAME_LEN, -1, '0, got, cycles);
        check("bp_bytes", 32'(got), 32'(FRAME_LEN));
        repeat (3) @(negedge clk);
        check("bp_no_extra", 32'(dout_valid), 32'd0);
        check("bp_busy", 32'(busy), 32'd0);

        // Second done during DATA is ignored and flags overrun.
        start_frame(vecs[0].pq);
        scan_timing(vecs[0].idx);
        collect(vecs[0].pq, vecs[0].idx, 1'b0, FRAME_LEN, 5, vecs[1].pq, got, cycles);
        check("ovr_bytes", 32'(got), 32'(FRAME_LEN));
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_idx_kept", 32'(class_idx), 32'(vecs[0].idx));
        start_frame(vecs[3].pq);
        check("ovr_cleared", 32'(overrun), 32'd0);
        check("cv_cleared", 32'(class_valid), 32'd0);
        scan_timing(vecs[3].idx);
        collect(vecs[3].pq, vecs[3].idx, 1'b0, FRAME_LEN, -1, '0, got, cycles);
        check("post_ovr_bytes", 32'(got), 32'(FRAME_LEN));

        // done on the same edge as the final handshake counts as busy.
        start_frame(vecs[1].pq);
        scan_timing(vecs[1].idx);
        collect(vecs[1].pq, vecs[1].idx, 1'b0, FRAME_LEN, FRAME_LEN - 1, vecs[2].pq, got, cycles);
        check("edge_bytes", 32'(got), 32'(FRAME_LEN));
        check("edge_overrun", 32'(overrun), 32'd1);
        repeat (2) @(negedge clk);
        check("edge_no_capture", 32'(busy), 32'd0);

        // Asynchronous reset after four bytes, between clock edges.
        start_frame(vecs[0].pq);
        scan_timing(vecs[0].idx);
        collect(vecs[0].pq, vecs[0].idx, 1'b0, 4, -1, '0, got, cycles);
        check("pre_rst_bytes", 32'(got), 32'd4);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(dout_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_class_valid", 32'(class_valid), 32'd0);
        check("arst_last", 32'(dout_last), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        start_frame(vecs[4].pq);
        scan_timing(vecs[4].idx);
        collect(vecs[4].pq, vecs[4].idx, 1'b0, FRAME_LEN, -1, '0, got, cycles);
        check("post_rst_bytes", 32'(got), 32'(FRAME_LEN));

        // done held for five cycles captures once.
        @(negedge clk);
        pq_in = vecs[1].pq;
        done  = 1'b1;
        repeat (5) @(negedge clk);
        done  = 1'b0;
        collect(vecs[1].pq, vecs[1].idx, 1'b0, FRAME_LEN, -1, '0, got, cycles);
        check("held_bytes", 32'(got), 32'(FRAME_LEN));
        check("held_overrun", 32'(overrun), 32'd1);
        check("held_idx", 32'(class_idx), 32'(vecs[1].idx));
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("held_single_frame", 32'(busy_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
